packet_field_extractor: RTL

- Upstream stage of the Q-table update block in the EER-RL cluster-head datapath.
- Accepts received packet words serially from the radio/receive FIFO interface and parses the header and destination.
- Filters out packets the node must ignore.
- Presents the decoded fields (fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH, fPacketType) with a one-cycle start pulse, then holds them until the Q-table block reports done.

---
 rtl/packet_field_extractor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/packet_field_extractor.sv
// Parses serial EER-RL packets (header, dest, 6 payload words), filters and presents fields to the Q-table stage.
// Latency: last payload word accepted at edge N -> fields valid and qt_en high for the cycle after edge N.
// Backpressure: in_ready drops from the issue cycle until qt_done; stalled words stay in the upstream FIFO.
module packet_field_extractor #(
    parameter int WORD_WIDTH = 16,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    output logic                  in_ready,
    output logic                  qt_en,
    input  logic                  qt_done,
    output logic [2:0]            fPacketType,
    output logic [WORD_WIDTH-1:0] fSourceID,
    output logic [WORD_WIDTH-1:0] fSourceHops,
    output logic [WORD_WIDTH-1:0] fClusterID,
    output logic [WORD_WIDTH-1:0] fEnergyLeft,
    output logic [WORD_WIDTH-1:0] fQValue,
    output logic [WORD_WIDTH-1:0] fKnownCH,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    typedef enum logic [2:0] {IDLE, DEST, PAYLOAD, ISSUE, WAIT_DONE} state_t;
    localparam int GAP_W = $clog2(TIMEOUT + 1);

    state_t                state, stateNext;
    logic [2:0]            typeSh;
    logic                  dropFlag, dropNext;
    logic [2:0]            idx;
    logic [GAP_W-1:0]      gapCnt;
    logic [WORD_WIDTH-1:0] srcSh, hopsSh, clusterSh, energySh, qSh;
    logic                  accept, sopAccept, hdrDrop, destBad, selfEcho;
    logic                  incDrop, loadOut, inPacket;

    assign in_ready  = (state == IDLE) || (state == DEST) || (state == PAYLOAD);
    assign qt_en     = (state == ISSUE);
    assign accept    = in_valid && in_ready;
    assign sopAccept = accept && in_sop;
    assign hdrDrop   = (in_data[WORD_WIDTH-1 -: 3] == 3'b000) || (in_data[WORD_WIDTH-1 -: 3] == 3'b111);
    assign destBad   = !((in_data == myNodeID) || (in_data == {WORD_WIDTH{1'b1}}));
    assign selfEcho  = (in_data == myNodeID);
    assign inPacket  = (state == DEST) || (state == PAYLOAD);

    always_comb begin
        stateNext = state;
        dropNext  = dropFlag;
        incDrop   = 1'b0;
        loadOut   = 1'b0;
        case (state)
            IDLE: begin
                if (sopAccept) begin
                    dropNext  = hdrDrop;
                    stateNext = DEST;
                end
            end
            DEST, PAYLOAD: begin
                if (sopAccept) begin
                    // a fresh header abandons the packet in flight and starts over
                    incDrop   = 1'b1;
                    dropNext  = hdrDrop;
                    stateNext = DEST;
                end else if (accept) begin
                    if (state == DEST) begin
                        dropNext  = dropFlag | destBad;
                        stateNext = PAYLOAD;
                    end else begin
                        if (idx == 3'd0) dropNext = dropFlag | selfEcho;
                        if (idx == 3'd5) begin
                            if (dropNext) begin
                                incDrop   = 1'b1;
                                stateNext = IDLE;
                            end else begin
                                loadOut   = 1'b1;
                                stateNext = ISSUE;
                            end
                        end
                    end
                end else if (gapCnt == GAP_W'(TIMEOUT - 1)) begin
                    incDrop   = 1'b1;
                    stateNext = IDLE;
                end
            end
            ISSUE:     stateNext = qt_done ? IDLE : WAIT_DONE;
            WAIT_DONE: if (qt_done) stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            dropFlag <= 1'b0;
            typeSh   <= '0;
            idx      <= '0;
            gapCnt   <= '0;
        end else begin
            state    <= stateNext;
            dropFlag <= dropNext;
            if (sopAccept) typeSh <= in_data[WORD_WIDTH-1 -: 3];
            if (sopAccept || (accept && state == DEST)) idx <= '0;
            else if (accept && state == PAYLOAD)        idx <= idx + 3'd1;
            if (inPacket && !accept && (stateNext == state)) gapCnt <= gapCnt + 1'b1;
            else                                              gapCnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            srcSh     <= '0;
            hopsSh    <= '0;
            clusterSh <= '0;
            energySh  <= '0;
            qSh       <= '0;
        end else if (accept && !in_sop && state == PAYLOAD) begin
            case (idx)
                3'd0:    srcSh     <= in_data;
                3'd1:    hopsSh    <= in_data;
                3'd2:    clusterSh <= in_data;
                3'd3:    energySh  <= in_data;
                3'd4:    qSh       <= in_data;
                default: ;
            endcase
        end
    end

    // the final payload word bypasses the shadow so fields are valid in the issue cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fPacketType <= '0;
            fSourceID   <= '0;
            fSourceHops <= '0;
            fClusterID  <= '0;
            fEnergyLeft <= '0;
            fQValue     <= '0;
            fKnownCH    <= '0;
            pkt_count   <= '0;
            drop_count  <= '0;
        end else begin
            if (loadOut) begin
                fPacketType <= typeSh;
                fSourceID   <= srcSh;
                fSourceHops <= hopsSh;
                fClusterID  <= clusterSh;
                fEnergyLeft <= energySh;
                fQValue     <= qSh;
                fKnownCH    <= in_data;
                if (pkt_count != {CNT_WIDTH{1'b1}}) pkt_count <= pkt_count + 1'b1;
            end
            if (incDrop && drop_count != {CNT_WIDTH{1'b1}}) drop_count <= drop_count + 1'b1;
        end
    end

endmodule
